// File: rtl/spi_pkg.sv
// Shared definitions for the byte-wide SPI master and its users.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } spi_state_t;

    localparam int SPI_CLK_DIV_DEFAULT = 8;

    // JEDEC read-ID opcode, sent by the flash self-test as its first byte.
    localparam logic [7:0] JEDEC_RDID = 8'h9F;

endpackage

// File: rtl/spi_tick_gen.sv
// Phase timer for the SPI master: one-cycle tick every CLK_DIV enabled clocks.
module spi_tick_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_byte_master.sv
// Mode-0, MSB-first, full-duplex byte SPI master clocked from the system clock.
module spi_byte_master
    import spi_pkg::*;
#(
    parameter int         CLK_DIV = SPI_CLK_DIV_DEFAULT,
    parameter logic [7:0] IDLE_TX = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enviar_dato,
    input  logic       recibir_dato,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       wait_n,
    output logic       spi_clk,
    output logic       spi_di,
    input  logic       spi_do
);

    spi_state_t state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] dout_q, dout_d;
    logic [7:0] tx_byte;
    logic       spi_clk_q, spi_clk_d;
    logic       spi_di_q, spi_di_d;
    logic       wait_n_q, wait_n_d;
    logic       accept;
    logic       tick;

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .clr  (accept),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        dout_d    = dout_q;
        spi_clk_d = spi_clk_q;
        spi_di_d  = spi_di_q;
        wait_n_d  = wait_n_q;
        accept    = 1'b0;
        tx_byte   = enviar_dato ? din : IDLE_TX;

        case (state_q)
            IDLE: begin
                if (enviar_dato || recibir_dato) begin
                    accept   = 1'b1;
                    shreg_d  = tx_byte;
                    spi_di_d = tx_byte[7];
                    wait_n_d = 1'b0;
                    bitcnt_d = 3'd0;
                    state_d  = LOW;
                end
            end
            LOW: begin
                // Capture on the rising edge; the vacated MSB becomes the next bit out.
                if (tick) begin
                    spi_clk_d = 1'b1;
                    shreg_d   = {shreg_q[6:0], spi_do};
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (tick) begin
                    spi_clk_d = 1'b0;
                    if (bitcnt_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        spi_di_d = shreg_q[7];
                        state_d  = LOW;
                    end
                end
            end
            DONE: begin
                dout_d   = shreg_q;
                wait_n_d = 1'b1;
                spi_di_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bitcnt_q  <= 3'd0;
            dout_q    <= 8'h00;
            spi_clk_q <= 1'b0;
            spi_di_q  <= 1'b1;
            wait_n_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            dout_q    <= dout_d;
            spi_clk_q <= spi_clk_d;
            spi_di_q  <= spi_di_d;
            wait_n_q  <= wait_n_d;
        end
    end

    // Shift register is pure data: always reloaded before it is used.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign dout    = dout_q;
    assign wait_n  = wait_n_q;
    assign spi_clk = spi_clk_q;
    assign spi_di  = spi_di_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Self-checking bench for spi_byte_master: vector table, slave model and scoreboard.
module tb_spi_byte_master;

    localparam int CLK_DIV = 8;
    localparam int XFER    = 16 * CLK_DIV + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       enviar_dato;
    logic       recibir_dato;
    logic [7:0] din;
    logic [7:0] dout;
    logic       wait_n;
    logic       spi_clk;
    logic       spi_di;
    logic       spi_do;

    always #5 clk = ~clk;

    spi_byte_master #(
        .CLK_DIV (CLK_DIV),
        .IDLE_TX (8'hFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enviar_dato  (enviar_dato),
        .recibir_dato (recibir_dato),
        .din          (din),
        .dout         (dout),
        .wait_n       (wait_n),
        .spi_clk      (spi_clk),
        .spi_di       (spi_di),
        .spi_do       (spi_do)
    );

    typedef struct {
        logic       send;
        logic       recv;
        logic [7:0] din;
        logic [7:0] miso;
        logic [7:0] exp_mosi;
        logic [7:0] exp_dout;
    } vec_t;

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] dout;
    } exp_t;

    vec_t vecs [6];
    exp_t sb [$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Monitor / slave-model state
    int         cyc_n     = 0;
    logic       prev_sck  = 1'b0;
    logic       prev_wait = 1'b1;
    logic       in_xfer   = 1'b0;
    int         last_edge = 0;
    int         rises     = 0;
    int         wait_cnt  = 0;
    int         bit_idx   = 0;
    int         start_cyc = 0;
    int         done_cyc  = 0;
    int         n_done    = 0;
    logic [7:0] mosi_sr   = 8'h00;
    logic [7:0] slave_byte = 8'h00;
    logic [7:0] dout_hold = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    task automatic monitor();
        exp_t e;
        cyc_n++;
        if (prev_wait && !wait_n) begin
            in_xfer   = 1'b1;
            start_cyc = cyc_n;
            last_edge = cyc_n;
            rises     = 0;
            bit_idx   = 0;
            wait_cnt  = 0;
            mosi_sr   = 8'h00;
            dout_hold = dout;
            spi_do    = slave_byte[7];
        end
        if (in_xfer && !wait_n) wait_cnt++;
        if (in_xfer && !prev_sck && spi_clk) begin
            chk("low_phase_len", cyc_n - last_edge, CLK_DIV);
            chk("dout_held", dout, dout_hold);
            last_edge = cyc_n;
            rises++;
            mosi_sr = {mosi_sr[6:0], spi_di};
        end
        if (in_xfer && prev_sck && !spi_clk) begin
            chk("high_phase_len", cyc_n - last_edge, CLK_DIV);
            last_edge = cyc_n;
            if (bit_idx < 7) bit_idx++;
            spi_do = slave_byte[7 - bit_idx];
        end
        if (in_xfer && !prev_wait && wait_n) begin
            in_xfer  = 1'b0;
            done_cyc = cyc_n;
            n_done++;
            chk("wait_low_cycles", wait_cnt, XFER);
            chk("sck_pulses", rises, 8);
            chk("sck_idle_after", spi_clk, 1'b0);
            chk("mosi_idle_after", spi_di, 1'b1);
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_xfer: got transfer with mosi %0h, required none", mosi_sr);
            end else begin
                e = sb.pop_front();
                chk("mosi_byte", mosi_sr, e.mosi);
                chk("dout", dout, e.dout);
            end
        end
        prev_sck  = spi_clk;
        prev_wait = wait_n;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic start(input logic s, input logic r, input logic [7:0] d,
                         input logic [7:0] miso, input logic [7:0] em, input logic [7:0] ed);
        exp_t e;
        e.mosi = em;
        e.dout = ed;
        sb.push_back(e);
        slave_byte   = miso;
        din          = d;
        enviar_dato  = s;
        recibir_dato = r;
        cyc();
        enviar_dato  = 1'b0;
        recibir_dato = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while (!(wait_n && !in_xfer) && k < max) begin
            cyc();
            k++;
        end
        if (!(wait_n && !in_xfer)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout_wait_idle: got wait_n=%0b after %0d cycles, required 1", wait_n, k);
        end
    endtask

    initial begin
        int first_done;
        int done_before;
        int k;

        vecs[0] = '{1'b1, 1'b0, 8'h9F, 8'h00, 8'h9F, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'hEF, 8'hFF, 8'hEF};
        vecs[2] = '{1'b1, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[3] = '{1'b1, 1'b1, 8'h12, 8'h81, 8'h12, 8'h81};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[5] = '{1'b0, 1'b1, 8'h77, 8'h5A, 8'hFF, 8'h5A};

        rst          = 1'b1;
        enviar_dato  = 1'b0;
        recibir_dato = 1'b0;
        din          = 8'h00;
        spi_do       = 1'b0;
        repeat (2) cyc();
        chk("rst_spi_clk", spi_clk, 1'b0);
        chk("rst_spi_di", spi_di, 1'b1);
        chk("rst_wait_n", wait_n, 1'b1);
        chk("rst_dout", dout, 8'h00);
        rst = 1'b0;
        repeat (3) cyc();

        for (int i = 0; i < 6; i++) begin
            start(vecs[i].send, vecs[i].recv, vecs[i].din, vecs[i].miso,
                  vecs[i].exp_mosi, vecs[i].exp_dout);
            wait_idle(XFER + 20);
            repeat (2) cyc();
        end
        chk("table_xfers", n_done, 6);

        // Strobe during a transfer is dropped, not queued
        done_before = n_done;
        start(1'b1, 1'b0, 8'hA5, 8'h6B, 8'hA5, 8'h6B);
        repeat (40) cyc();
        din         = 8'h55;
        enviar_dato = 1'b1;
        cyc();
        enviar_dato = 1'b0;
        chk("busy_wait_n", wait_n, 1'b0);
        wait_idle(XFER + 20);
        repeat (2 * XFER / 4) cyc();
        chk("single_xfer", n_done, done_before + 1);
        chk("idle_after_ignored", wait_n, 1'b1);
        chk("sb_empty", sb.size(), 0);

        // Asynchronous reset in the middle of bit 4
        done_before = n_done;
        start(1'b1, 1'b0, 8'hC7, 8'h11, 8'hC7, 8'h11);
        k = 0;
        while (rises < 5 && k < XFER) begin
            cyc();
            k++;
        end
        chk("reached_bit4", rises, 5);
        repeat (3) cyc();
        rst = 1'b1;
        #1;
        chk("abort_spi_clk", spi_clk, 1'b0);
        chk("abort_spi_di", spi_di, 1'b1);
        chk("abort_wait_n", wait_n, 1'b1);
        chk("abort_dout", dout, 8'h00);
        sb.delete();
        in_xfer   = 1'b0;
        prev_sck  = spi_clk;
        prev_wait = wait_n;
        repeat (2) cyc();
        rst = 1'b0;
        repeat (2) cyc();
        chk("abort_no_done", n_done, done_before);
        start(1'b1, 1'b0, 8'h3C, 8'h96, 8'h3C, 8'h96);
        wait_idle(XFER + 20);
        chk("post_rst_dout", dout, 8'h96);

        // Both strobes together, then a receive issued the cycle wait_n rises
        repeat (3) cyc();
        start(1'b1, 1'b1, 8'h12, 8'hB4, 8'h12, 8'hB4);
        wait_idle(XFER + 20);
        first_done = done_cyc;
        start(1'b0, 1'b1, 8'h34, 8'hC3, 8'hFF, 8'hC3);
        chk("b2b_gap", start_cyc - first_done, 1);
        wait_idle(XFER + 20);
        repeat (5) cyc();
        chk("final_sb_empty", sb.size(), 0);
        chk("final_dout", dout, 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
